adder_seq_n_bit: RTL and testbench

- Parametrised, multi-cycle successor to the 4-bit dataflow adder.
- Adds two WIDTH-bit operands plus a carry-in, SLICE bits per clock, using a shared carry register.
- Start/busy/done handshake; the result is registered and held until the next operation completes.
- Sits in the Chapter 4/5 arithmetic set as the first clocked adder and serves as the datapath core for later accumulator/ALU blocks.

---
 rtl/adder_pkg.sv | 18 +
 rtl/adder_slice_df.sv | 14 +
 rtl/adder_seq_n_bit.sv | 132 +++++++++++++
 tb/tb_adder_seq_n_bit.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared types and elaboration helpers for the sequential slice adder family.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  function automatic int calc_nslice(input int width, input int slice);
    return (slice > 0) ? (width / slice) : 1;
  endfunction

  function automatic bit slice_legal(input int width, input int slice);
    return (width >= 1) && (slice >= 1) && (slice <= width) && ((width % slice) == 0);
  endfunction

endpackage

// File: rtl/adder_slice_df.sv
// Combinational SLICE-bit dataflow adder: {o_cout, o_s} = i_a + i_b + i_cin.
module adder_slice_df #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] i_a,
  input  logic [SLICE-1:0] i_b,
  input  logic             i_cin,
  output logic [SLICE-1:0] o_s,
  output logic             o_cout
);

  assign {o_cout, o_s} = {1'b0, i_a} + {1'b0, i_b} + {{SLICE{1'b0}}, i_cin};

endmodule

// File: rtl/adder_seq_n_bit.sv
// Multi-cycle WIDTH-bit adder, SLICE bits per clock, start/busy/done handshake.
// Define ADDER_SEQ_OVERFLOW_EN to add the registered two's-complement overflow output V.
module adder_seq_n_bit #(
  parameter int WIDTH = 8,
  parameter int SLICE = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C0,
  output logic [WIDTH-1:0] Sum,
  output logic             C4,
  output logic             busy,
  output logic             done
`ifdef ADDER_SEQ_OVERFLOW_EN
  ,
  output logic             V
`endif
);
  import adder_pkg::*;

  localparam int NSLICE = calc_nslice(WIDTH, SLICE);
  localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NSLICE - 1);

  generate
    if (!slice_legal(WIDTH, SLICE)) begin : g_bad_params
      $error("adder_seq_n_bit: WIDTH must be a positive multiple of SLICE");
    end
  endgenerate

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_opa, r_opb, r_work;
  logic             r_cy;
  logic [CNT_W-1:0] r_cnt;
  logic [SLICE-1:0] w_s;
  logic             w_c;
  logic [WIDTH-1:0] w_work_nxt;
  logic             w_load, w_last;

  adder_slice_df #(.SLICE(SLICE)) u_slice (
    .i_a    (r_opa[SLICE-1:0]),
    .i_b    (r_opb[SLICE-1:0]),
    .i_cin  (r_cy),
    .o_s    (w_s),
    .o_cout (w_c)
  );

  // Each new slice enters at the MSB end, so after NSLICE shifts the LSB slice sits at bit 0.
  assign w_work_nxt = (r_work >> SLICE) | (WIDTH'(w_s) << (WIDTH - SLICE));

`ifdef ADDER_SEQ_OVERFLOW_EN
  logic w_v;
  // Carry into the MSB is recovered from the MSB sum bit and its operand bits.
  assign w_v = r_opa[SLICE-1] ^ r_opb[SLICE-1] ^ w_s[SLICE-1] ^ w_c;
`endif

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    w_load      = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_load      = 1'b1;
          w_state_nxt = BUSY;
        end
      end
      BUSY: begin
        busy = 1'b1;
        if (r_cnt == CNT_LAST) begin
          w_last      = 1'b1;
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          w_load      = 1'b1;
          w_state_nxt = BUSY;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_opa  <= '0;
      r_opb  <= '0;
      r_work <= '0;
      r_cy   <= 1'b0;
      r_cnt  <= '0;
      Sum    <= '0;
      C4     <= 1'b0;
`ifdef ADDER_SEQ_OVERFLOW_EN
      V      <= 1'b0;
`endif
    end else if (w_load) begin
      r_opa <= A;
      r_opb <= B;
      r_cy  <= C0;
      r_cnt <= '0;
    end else if (r_state == BUSY) begin
      r_opa  <= r_opa >> SLICE;
      r_opb  <= r_opb >> SLICE;
      r_cy   <= w_c;
      r_cnt  <= r_cnt + CNT_W'(1);
      r_work <= w_work_nxt;
      // Result registers only move on the final slice, never showing partial sums.
      if (w_last) begin
        Sum <= w_work_nxt;
        C4  <= w_c;
`ifdef ADDER_SEQ_OVERFLOW_EN
        V   <= w_v;
`endif
      end
    end
  end

endmodule

// File: tb/tb_adder_seq_n_bit.sv
// Self-checking bench: directed handshake cases on an 8/4 instance plus a random 16-bit slice sweep.
module tb_adder_seq_n_bit;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  logic       start8, C08, C48, busy8, done8;
  logic [7:0] A8, B8, Sum8;
  logic [7:0] exp_sum8;
  logic       exp_c48, exp_v8;
`ifdef ADDER_SEQ_OVERFLOW_EN
  logic       V8;
`endif

  adder_seq_n_bit #(.WIDTH(8), .SLICE(4)) u_dut8 (
    .clock (clock),
    .reset (reset),
    .start (start8),
    .A     (A8),
    .B     (B8),
    .C0    (C08),
    .Sum   (Sum8),
    .C4    (C48),
    .busy  (busy8),
    .done  (done8)
`ifdef ADDER_SEQ_OVERFLOW_EN
    ,
    .V     (V8)
`endif
  );

  logic        start16, C016;
  logic [15:0] A16, B16;
  logic [15:0] sum16 [3];
  logic        c416 [3], busy16 [3], done16 [3];
`ifdef ADDER_SEQ_OVERFLOW_EN
  logic        v16 [3];
`endif

  function automatic int sl16(input int i);
    return (i == 0) ? 1 : ((i == 1) ? 4 : 16);
  endfunction

  generate
    for (genvar g = 0; g < 3; g++) begin : g16
      adder_seq_n_bit #(.WIDTH(16), .SLICE((g == 0) ? 1 : ((g == 1) ? 4 : 16))) u_dut (
        .clock (clock),
        .reset (reset),
        .start (start16),
        .A     (A16),
        .B     (B16),
        .C0    (C016),
        .Sum   (sum16[g]),
        .C4    (c416[g]),
        .busy  (busy16[g]),
        .done  (done16[g])
`ifdef ADDER_SEQ_OVERFLOW_EN
        ,
        .V     (v16[g])
`endif
      );
    end
  endgenerate

  // Reference: plain unsigned sum with carry, signed range test for overflow.
  function automatic logic [16:0] ref_add(input logic [15:0] a, input logic [15:0] b, input logic c);
    int unsigned s;
    s = int'(a) + int'(b) + int'(c);
    return 17'(s);
  endfunction

  function automatic logic ref_ovf(input int w, input logic [15:0] a, input logic [15:0] b, input logic c);
    int half, sa, sb, s;
    half = 1 << (w - 1);
    sa = (int'(a) >= half) ? int'(a) - 2 * half : int'(a);
    sb = (int'(b) >= half) ? int'(b) - 2 * half : int'(b);
    s  = sa + sb + int'(c);
    return (s >= half) || (s < -half);
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle8(input string tag);
    check({tag, "_sum"},  32'(Sum8),  32'(exp_sum8));
    check({tag, "_c4"},   32'(C48),   32'(exp_c48));
    check({tag, "_busy"}, 32'(busy8), 32'd0);
    check({tag, "_done"}, 32'(done8), 32'd0);
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic c, input string tag);
    logic [16:0] r;
    A8 = a; B8 = b; C08 = c; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    A8 = 8'($urandom); B8 = 8'($urandom); C08 = ~c;
    check({tag, "_busy1"}, 32'(busy8), 32'd1);
    check({tag, "_hold1"}, 32'(Sum8),  32'(exp_sum8));
    tick();
    check({tag, "_busy2"}, 32'(busy8), 32'd1);
    check({tag, "_hold2"}, 32'(Sum8),  32'(exp_sum8));
    check({tag, "_hc4"},   32'(C48),   32'(exp_c48));
    tick();
    r = ref_add({8'h00, a}, {8'h00, b}, c);
    exp_sum8 = r[7:0];
    exp_c48  = r[8];
    exp_v8   = ref_ovf(8, {8'h00, a}, {8'h00, b}, c);
    check({tag, "_done"},   32'(done8), 32'd1);
    check({tag, "_dbusy"},  32'(busy8), 32'd0);
    check({tag, "_sum"},    32'(Sum8),  32'(exp_sum8));
    check({tag, "_c4"},     32'(C48),   32'(exp_c48));
`ifdef ADDER_SEQ_OVERFLOW_EN
    check({tag, "_v"},      32'(V8),    32'(exp_v8));
`endif
    tick();
    check_idle8({tag, "_after"});
  endtask

  initial begin
    int          lat [3], ndone [3], nbusy [3];
    logic [15:0] got_s [3];
    logic        got_c [3];
`ifdef ADDER_SEQ_OVERFLOW_EN
    logic        got_v [3];
`endif
    logic [15:0] a, b;
    logic        c;
    logic [16:0] r;

    start8 = 1'b0; A8 = '0; B8 = '0; C08 = 1'b0;
    start16 = 1'b0; A16 = '0; B16 = '0; C016 = 1'b0;
    exp_sum8 = '0; exp_c48 = 1'b0; exp_v8 = 1'b0;

    reset = 1'b1;
    tick();
    tick();
    check_idle8("reset");
    for (int i = 0; i < 3; i++) begin
      check("reset16_sum",  32'(sum16[i]),  32'd0);
      check("reset16_busy", 32'(busy16[i]), 32'd0);
    end
    reset = 1'b0;
    tick();

    run8(8'hAA, 8'h55, 1'b0, "aa55_c0");
    check("aa55_const", 32'(exp_sum8), 32'h00FF);
    run8(8'hAA, 8'h55, 1'b1, "aa55_c1");
    run8(8'h00, 8'h00, 1'b0, "zero");
`ifdef ADDER_SEQ_OVERFLOW_EN
    run8(8'h7F, 8'h01, 1'b0, "ovf_pos");
    run8(8'hFF, 8'h01, 1'b0, "ovf_none");
`endif

    // Back-to-back with start held high; operands disturbed mid-operation.
    A8 = 8'h5A; B8 = 8'hA5; C08 = 1'b0; start8 = 1'b1;
    tick();
    A8 = 8'h01; B8 = 8'hFF;
    check("b2b_busy1", 32'(busy8), 32'd1);
    tick();
    check("b2b_busy2", 32'(busy8), 32'd1);
    check("b2b_hold",  32'(Sum8),  32'(exp_sum8));
    tick();
    check("b2b_done1", 32'(done8), 32'd1);
    check("b2b_sum1",  32'(Sum8),  32'h00FF);
    check("b2b_c41",   32'(C48),   32'd0);
    tick();
    check("b2b_busy3", 32'(busy8), 32'd1);
    check("b2b_nodone", 32'(done8), 32'd0);
    check("b2b_hold2", 32'(Sum8),  32'h00FF);
    A8 = 8'h33; B8 = 8'h33;
    tick();
    start8 = 1'b0;
    check("b2b_busy4", 32'(busy8), 32'd1);
    tick();
    check("b2b_done2", 32'(done8), 32'd1);
    check("b2b_sum2",  32'(Sum8),  32'h0000);
    check("b2b_c42",   32'(C48),   32'd1);
    exp_sum8 = 8'h00; exp_c48 = 1'b1;
    tick();
    check_idle8("b2b_idle");

    // Reset during the second BUSY cycle aborts without a done pulse.
    A8 = 8'h12; B8 = 8'h34; C08 = 1'b1; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    check("abort_busy1", 32'(busy8), 32'd1);
    tick();
    check("abort_busy2", 32'(busy8), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_sum8 = '0; exp_c48 = 1'b0; exp_v8 = 1'b0;
    check_idle8("abort_rst");
    tick();
    check_idle8("abort_q1");
    tick();
    check_idle8("abort_q2");
    run8(8'h12, 8'h34, 1'b1, "post_abort");

    for (int n = 0; n < 40; n++) begin
      run8(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), "rnd8");
    end

    // 16-bit sweep over SLICE = 1, 4, 16.
    for (int op = 0; op < 200; op++) begin
      a = 16'($urandom); b = 16'($urandom); c = 1'($urandom_range(0, 1));
      if (op == 0) begin a = 16'hFFFF; b = 16'h0000; c = 1'b1; end
      if (op == 1) begin a = 16'hFFFF; b = 16'hFFFF; c = 1'b1; end
      if (op == 2) begin a = 16'h7FFF; b = 16'h0000; c = 1'b1; end
      A16 = a; B16 = b; C016 = c; start16 = 1'b1;
      tick();
      start16 = 1'b0;
      A16 = 16'($urandom); B16 = 16'($urandom); C016 = ~c;
      for (int i = 0; i < 3; i++) begin
        lat[i] = -1; ndone[i] = 0; got_s[i] = 'x; got_c[i] = 1'bx;
        nbusy[i] = busy16[i] ? 1 : 0;
`ifdef ADDER_SEQ_OVERFLOW_EN
        got_v[i] = 1'bx;
`endif
      end
      for (int cyc = 1; cyc <= 20; cyc++) begin
        tick();
        for (int i = 0; i < 3; i++) begin
          if (busy16[i]) nbusy[i]++;
          if (done16[i]) begin
            ndone[i]++;
            if (lat[i] < 0) begin
              lat[i] = cyc; got_s[i] = sum16[i]; got_c[i] = c416[i];
`ifdef ADDER_SEQ_OVERFLOW_EN
              got_v[i] = v16[i];
`endif
            end
          end
        end
      end
      r = ref_add(a, b, c);
      for (int i = 0; i < 3; i++) begin
        check("sw_latency", 32'(lat[i]),   32'(16 / sl16(i)));
        check("sw_ndone",   32'(ndone[i]), 32'd1);
        check("sw_nbusy",   32'(nbusy[i]), 32'(16 / sl16(i)));
        check("sw_sum",     32'(got_s[i]), 32'(r[15:0]));
        check("sw_c4",      32'(got_c[i]), 32'(r[16]));
`ifdef ADDER_SEQ_OVERFLOW_EN
        check("sw_v",       32'(got_v[i]), 32'(ref_ovf(16, a, b, c)));
`endif
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
